// File: rtl/combo_lock_core.sv
// rtl/combo_lock_core.sv - combination-lock engine with attempt limit, timed lockout, auto-relock and reprogramming
module combo_lock_core #(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 20,
  parameter int UNLOCK_CYCLES  = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DIGIT_W-1:0]                digit_in,
  input  logic                              enter,
  input  logic                              clear,
  input  logic                              prog,
  output logic                              unlocked,
  output logic                              locked_out,
  output logic                              err,
  output logic [1:0]                        state,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt,
  output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left
);
  localparam int CW   = $clog2(CODE_LEN+1);
  localparam int TRW  = $clog2(MAX_TRIES+1);
  localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW   = $clog2(TMAX+1);

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    PROGRAM = 2'd2,
    LOCKOUT = 2'd3
  } lockState_t;

  lockState_t                          curState;
  logic [CODE_LEN-1:0][DIGIT_W-1:0]    code;
  logic [CODE_LEN-1:0][DIGIT_W-1:0]    shadow;
  logic [CODE_LEN-1:0][DIGIT_W-1:0]    shadowNext;
  logic [DIGIT_W-1:0]                  expDigit;
  logic [TW-1:0]                       timer;
  logic                                mismatch;
  logic                                lastDigit;
  logic                                codeWrong;

  // Entry index k lives in the most-significant-first slot CODE_LEN-1-k.
  always_comb begin
    expDigit   = '0;
    shadowNext = shadow;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (CW'(i) == digit_cnt) begin
        expDigit                 = code[CODE_LEN-1-i];
        shadowNext[CODE_LEN-1-i] = digit_in;
      end
    end
  end

  assign lastDigit = (digit_cnt == CW'(CODE_LEN-1));
  assign codeWrong = mismatch || (digit_in != expDigit);
  assign state     = curState;

  always_ff @(posedge clk) begin
    if (rst) begin
      curState   <= LOCKED;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      err        <= 1'b0;
      digit_cnt  <= '0;
      tries_left <= TRW'(MAX_TRIES);
      code       <= DEFAULT_CODE;
      shadow     <= DEFAULT_CODE;
      mismatch   <= 1'b0;
      timer      <= '0;
    end else begin
      err <= 1'b0;
      case (curState)
        LOCKED: begin
          if (clear) begin
            digit_cnt <= '0;
            mismatch  <= 1'b0;
          end else if (enter) begin
            if (lastDigit) begin
              digit_cnt <= '0;
              mismatch  <= 1'b0;
              if (!codeWrong) begin
                curState   <= OPEN;
                unlocked   <= 1'b1;
                tries_left <= TRW'(MAX_TRIES);
                timer      <= TW'(UNLOCK_CYCLES);
              end else begin
                err <= 1'b1;
                if (tries_left > TRW'(1)) begin
                  tries_left <= tries_left - TRW'(1);
                end else begin
                  tries_left <= '0;
                  curState   <= LOCKOUT;
                  locked_out <= 1'b1;
                  timer      <= TW'(LOCKOUT_CYCLES);
                end
              end
            end else begin
              digit_cnt <= digit_cnt + CW'(1);
              mismatch  <= codeWrong;
            end
          end
        end
        OPEN: begin
          if (clear) begin
            curState <= LOCKED;
            unlocked <= 1'b0;
            timer    <= '0;
          end else if (prog) begin
            curState  <= PROGRAM;
            digit_cnt <= '0;
          end else if (timer <= TW'(1)) begin
            curState <= LOCKED;
            unlocked <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        PROGRAM: begin
          if (clear) begin
            curState  <= LOCKED;
            unlocked  <= 1'b0;
            digit_cnt <= '0;
            timer     <= '0;
          end else if (enter) begin
            shadow <= shadowNext;
            if (lastDigit) begin
              code      <= shadowNext;
              digit_cnt <= '0;
              curState  <= LOCKED;
              unlocked  <= 1'b0;
              timer     <= '0;
            end else begin
              digit_cnt <= digit_cnt + CW'(1);
            end
          end
        end
        LOCKOUT: begin
          if (timer <= TW'(1)) begin
            curState   <= LOCKED;
            locked_out <= 1'b0;
            tries_left <= TRW'(MAX_TRIES);
            timer      <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: curState <= LOCKED;
      endcase
    end
  end
endmodule

// File: tb/tb_combo_lock_core.sv
// tb/tb_combo_lock_core.sv - directed self-checking bench for combo_lock_core
module tb_combo_lock_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digitIn = '0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       prog = 1'b0;
  logic       unlocked, lockedOut, err;
  logic [1:0] state;
  logic [2:0] digitCnt;
  logic [1:0] triesLeft;
  int         passCnt = 0;
  int         checkCnt = 0;

  combo_lock_core dut (
    .clk(clk), .rst(rst), .digit_in(digitIn), .enter(enter), .clear(clear), .prog(prog),
    .unlocked(unlocked), .locked_out(lockedOut), .err(err), .state(state),
    .digit_cnt(digitCnt), .tries_left(triesLeft)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    checkCnt++;
    if (got == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pressDigit(input logic [3:0] d);
    digitIn = d;
    enter = 1'b1;
    tick(1);
    enter = 1'b0;
  endtask

  task automatic pressCode(input logic [15:0] c);
    pressDigit(c[15:12]);
    pressDigit(c[11:8]);
    pressDigit(c[7:4]);
    pressDigit(c[3:0]);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic pulseProg();
    prog = 1'b1;
    tick(1);
    prog = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_state"}, state, 0);
    checkVal({tag, "_unlocked"}, unlocked, 0);
    checkVal({tag, "_lockedout"}, lockedOut, 0);
    checkVal({tag, "_err"}, err, 0);
    checkVal({tag, "_digitcnt"}, digitCnt, 0);
    checkVal({tag, "_tries"}, triesLeft, 3);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    checkReset("reset");

    // correct code, then auto-relock after exactly 10 cycles
    pressCode(16'h1234);
    checkVal("open_state", state, 1);
    checkVal("open_unlocked", unlocked, 1);
    checkVal("open_tries", triesLeft, 3);
    tick(9);
    checkVal("open_last_cycle", state, 1);
    tick(1);
    checkVal("relock_state", state, 0);
    checkVal("relock_unlocked", unlocked, 0);

    // one wrong code
    pressCode(16'h1235);
    checkVal("wrong_err", err, 1);
    checkVal("wrong_tries", triesLeft, 2);
    checkVal("wrong_state", state, 0);
    checkVal("wrong_digitcnt", digitCnt, 0);
    tick(1);
    checkVal("wrong_err_drop", err, 0);
    pressCode(16'h1234);
    checkVal("retry_state", state, 1);
    checkVal("retry_tries", triesLeft, 3);
    pulseClear();
    checkVal("clear_relock", state, 0);

    // three wrong codes into lockout
    pressCode(16'h9999);
    checkVal("w1_tries", triesLeft, 2);
    pressCode(16'h9999);
    checkVal("w2_tries", triesLeft, 1);
    pressCode(16'h9999);
    checkVal("w3_err", err, 1);
    checkVal("w3_state", state, 3);
    checkVal("w3_lockedout", lockedOut, 1);
    checkVal("w3_tries", triesLeft, 0);
    pressCode(16'h1234);
    checkVal("lockout_ignores", state, 3);
    checkVal("lockout_unlocked", unlocked, 0);
    tick(15);
    checkVal("lockout_last", state, 3);
    tick(1);
    checkVal("lockout_end_state", state, 0);
    checkVal("lockout_end_tries", triesLeft, 3);
    checkVal("lockout_end_flag", lockedOut, 0);

    // partial entry abandoned by clear, also clear beating enter
    pressDigit(4'd1);
    pressDigit(4'd2);
    checkVal("partial_cnt", digitCnt, 2);
    pulseClear();
    checkVal("clear_cnt", digitCnt, 0);
    checkVal("clear_tries", triesLeft, 3);
    pressDigit(4'd1);
    digitIn = 4'd2;
    enter = 1'b1;
    clear = 1'b1;
    tick(1);
    enter = 1'b0;
    clear = 1'b0;
    checkVal("clear_enter_cnt", digitCnt, 0);
    pressCode(16'h1234);
    checkVal("after_clear_open", state, 1);

    // reprogram to 5678
    pulseProg();
    checkVal("prog_state", state, 2);
    checkVal("prog_unlocked", unlocked, 1);
    pressDigit(4'd5);
    pressDigit(4'd6);
    pressDigit(4'd7);
    checkVal("prog_cnt", digitCnt, 3);
    pressDigit(4'd8);
    checkVal("prog_done_state", state, 0);
    checkVal("prog_done_cnt", digitCnt, 0);
    pressCode(16'h1234);
    checkVal("old_code_err", err, 1);
    checkVal("old_code_state", state, 0);
    pressCode(16'h5678);
    checkVal("new_code_open", state, 1);
    checkVal("new_code_tries", triesLeft, 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkVal("rst_relock", state, 0);
    pressCode(16'h1234);
    checkVal("rst_default_code", state, 1);

    // aborted programming keeps the old code
    pulseProg();
    pressDigit(4'd9);
    pressDigit(4'd9);
    checkVal("abort_cnt", digitCnt, 2);
    pulseClear();
    checkVal("abort_state", state, 0);
    checkVal("abort_cnt_zero", digitCnt, 0);
    pressCode(16'h1234);
    checkVal("abort_code_kept", state, 1);
    pulseClear();

    // reset mid-entry
    pressCode(16'h9999);
    checkVal("pre_rst_tries", triesLeft, 2);
    pressDigit(4'd1);
    pressDigit(4'd2);
    checkVal("pre_rst_cnt", digitCnt, 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkReset("midrst");

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule

// File: doc/combo_lock_core.md
Name: combo_lock_core

Overview:
- Parametrised combination-lock engine behind the board-level lock top.
- Accepts digits (switch value plus a one-cycle enter pulse) and compares them against a stored code of CODE_LEN digits, each DIGIT_W bits wide.
- Adds behaviour the first-generation lock lacks: an attempt limit with timed lockout, timed auto-relock, and in-field reprogramming of the code.
- Button inputs arrive already debounced and edge-detected as single-cycle pulses. Outputs feed the LED and seven-segment drivers.

Parameters:
- DIGIT_W, 4, bits per digit.
- CODE_LEN, 4, digits per code (>=1).
- DEFAULT_CODE, 16'h1234, CODE_LEN*DIGIT_W bits; code loaded at reset. First-entered digit is the MS digit.
- MAX_TRIES, 3, wrong codes allowed before lockout (>=1).
- LOCKOUT_CYCLES, 20, clk cycles spent in lockout (>=1).
- UNLOCK_CYCLES, 10, clk cycles OPEN stays before auto-relock (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- digit_in  in  DIGIT_W  digit value, sampled only when enter=1.
- enter  in  1  single-cycle pulse, submits digit_in.
- clear  in  1  single-cycle pulse, abandons the current entry; in OPEN, relocks immediately.
- prog  in  1  single-cycle pulse; in OPEN, enters PROGRAM.
- unlocked  out  1  high in OPEN and PROGRAM.
- locked_out  out  1  high in LOCKOUT.
- err  out  1  one-cycle pulse after a wrong complete code.
- state  out  2  LOCKED=0, OPEN=1, PROGRAM=2, LOCKOUT=3.
- digit_cnt  out  $clog2(CODE_LEN+1)  digits accepted in the current entry.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts.

Behaviour:
- All outputs are registered. Reset values:
  - state=LOCKED, unlocked=0, locked_out=0, err=0, digit_cnt=0, tries_left=MAX_TRIES.
  - Code register=DEFAULT_CODE, mismatch flag=0, timer=0.
- Reset mid-operation restores all of the above, including discarding any programmed code. Reset overrides all inputs.
- Input priority in the same cycle: clear > prog > enter.
- LOCKED:
  - enter compares digit_in with code digit index digit_cnt (index 0 = bits [CODE_LEN*DIGIT_W-1 -: DIGIT_W]). Any inequality sets the mismatch flag. digit_cnt increments.
  - On the enter that completes CODE_LEN digits, evaluation includes that digit and digit_cnt and mismatch clear.
  - Correct code: next cycle state=OPEN, unlocked=1, tries_left=MAX_TRIES, timer=UNLOCK_CYCLES.
  - Wrong code with tries_left>1: err=1 for exactly one cycle, tries_left decrements, state stays LOCKED.
  - Wrong code with tries_left==1: err=1 for one cycle, tries_left=0, state=LOCKOUT, timer=LOCKOUT_CYCLES.
  - clear: digit_cnt=0, mismatch=0, no try consumed.
  - prog is ignored.
- OPEN:
  - Timer decrements each cycle. On the cycle it would reach 0, next state=LOCKED. OPEN lasts exactly UNLOCK_CYCLES cycles.
  - clear: immediate relock (LOCKED next cycle).
  - prog: PROGRAM next cycle, digit_cnt=0.
  - enter ignored.
- PROGRAM:
  - unlocked stays 1; the timer is frozen.
  - enter writes digit_in into a shadow code at index digit_cnt, and digit_cnt increments.
  - On the CODE_LEN-th digit, the code register takes the full shadow in the same update, digit_cnt=0, and state=LOCKED next cycle.
  - clear aborts: code unchanged, digit_cnt=0, LOCKED.
  - prog ignored.
- LOCKOUT:
  - locked_out=1; enter, clear and prog are all ignored.
  - Timer decrements. After exactly LOCKOUT_CYCLES cycles in LOCKOUT: LOCKED, tries_left=MAX_TRIES, locked_out=0.
- Counter/arithmetic rules:
  - digit_cnt never exceeds CODE_LEN-1 while visible.
  - tries_left never underflows.
  - The timer is sized to $clog2(max(LOCKOUT_CYCLES,UNLOCK_CYCLES)+1) bits and never wraps.
- Latency: enter → result visible one cycle later. No combinational input-to-output paths.

Test Plan:
- Defaults (code 1234). Enter 1,2,3,4 on separate cycles → cycle after the 4th enter: state=1, unlocked=1, tries_left=3. Exactly 10 cycles later: state=0, unlocked=0.
- Enter 1,2,3,5 → one-cycle err pulse, tries_left=2, state=0, digit_cnt=0. Then 1,2,3,4 → OPEN, tries_left=3.
- Three wrong codes (9,9,9,9 each) → third err coincides with state=3 and locked_out=1. During lockout, enter 1,2,3,4 has no effect. After 20 cycles: state=0, tries_left=3.
- Enter 1,2, then clear (and a separate cycle with clear and enter together) → digit_cnt=0, tries_left unchanged at 3. Then 1,2,3,4 unlocks.
- Sequence:
  - Unlock, prog, enter 5,6,7,8 → state=0.
  - Code 1234 now errs; 5678 unlocks.
  - Assert rst → 1234 unlocks again.
- Unlock, prog, enter 9,9, clear → code unchanged (1234 unlocks). Assert rst mid-entry (digit_cnt=2) → all outputs at reset values the next cycle.
